srm_datapath: RTL and testbench
===============================

# srm_datapath

Datapath of the Simple RISC Machine: an 8×16-bit register file, pipeline operand registers A and B, a barrel shifter on the B operand, a 4-function 16-bit ALU, result register C and a 3-bit status register (Z, N, V). A finite-state controller drives all selects and load enables. The block exposes C as `datapath_out` and the latched flags to that controller.

## Interface
Parameters: none (width fixed at 16, 8 registers).
- `clk` in 1: single clock; all state updates on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `mdata` in 16: memory read data (write-back source)
- `sximm8` in 16: sign-extended 8-bit immediate (write-back source)
- `sximm5` in 16: sign-extended 5-bit immediate (B-side ALU source)
- `PC` in 8: program counter (write-back source, zero-extended)
- `write` in 1: register-file write enable
- `vsel` in 2: write-back select
- `writenum` in 3: register-file write index
- `readnum` in 3: register-file read index
- `loada`, `loadb` in 1: load enables for A and B
- `asel` in 1: 1 = ALU A input forced to 0
- `bsel` in 1: 1 = ALU B input is `sximm5`
- `shift` in 2: shifter operation on B
- `ALUop` in 2: ALU operation
- `loadc`, `loads` in 1: load enables for C and status
- `datapath_out` out 16: contents of C
- `Z`, `N`, `V` out 1: status register contents

## Operation
- Write-back mux `vsel`: 00 = C (`datapath_out`), 01 = {8'b0, PC}, 10 = `sximm8`, 11 = `mdata`.
- Register file: combinational read of R[`readnum`]. On clk rise with `write`=1, R[`writenum`] gets the write-back value.
- A and B capture the read data on clk rise when `loada`/`loadb`=1, else hold.
- Shifter on B with `shift`:
  - 00: pass.
  - 01: shift left 1, LSB=0.
  - 10: logical right 1, MSB=0.
  - 11: arithmetic right 1, MSB kept.
- Ain = `asel` ? 0 : A. Bin = `bsel` ? `sximm5` : shifted B.
- ALU `ALUop`:
  - 00: Ain+Bin.
  - 01: Ain−Bin.
  - 10: Ain&Bin.
  - 11: ~Bin.
  - All results are modulo 2^16.
- Flags, computed from the ALU result:
  - Z = (result==0).
  - N = result[15].
  - V = signed overflow. For add: operands have the same sign and the result sign differs. For sub: operands have different signs and the result sign differs from Ain. V = 0 for AND and NOT.
- C takes the result on clk rise when `loadc`=1. {Z,N,V} take the flags on clk rise when `loads`=1. Both are independent of each other.
- Reset (`rst_n`=0, asynchronous): R0–R7, A, B, C and the status register clear to 0. So `datapath_out`=0 and Z=N=V=0, regardless of clk. Reset dominates all load enables.

## Timing
- Read path is combinational: a value loaded into A/B appears on the same edge it is captured.
- A write is visible on the read port after the writing edge. A same-edge `loada` with `write` to the same register captures the old value.
- Write-back with `vsel`=00 uses the pre-edge C. C load and register write on the same edge therefore write the old C.
- Latency: register → A/B (1 edge) → C/status (1 edge) → register file (1 edge).
- Outputs change only on clk rise or on reset assertion. Reset release requires no synchronizer inside this block.

## Structure
- Shared package `srm_pkg`:
  - enums/localparams for `vsel`, `shift` and `ALUop` encodings.
  - width constant 16 and register count 8.
- One natural sub-module: `srm_regfile` (8×16, one combinational read port, one synchronous write port, async active-low clear).
- Shifter, ALU and flag logic are inline combinational blocks in the top.

## Test plan
- MOV/shift/add:
  - Write 7→R0 and 2→R1 via `vsel`=10.
  - Load B=R0, A=R1; `shift`=01, ALUop=00.
  - Expect C=16, Z=N=V=0.
  - Write back to R2 with `vsel`=00; expect R2 reads 16.
- Add: R3=42, R5=13; A=R5, B=R3, ADD → C=55. With `asel`=1, B=R3 → C=42; writing back to R7 gives R7=42.
- Overflow: R0=R1=20000, ADD → C=0x9C40, N=1, V=1, Z=0.
- Sub/flags:
  - 5−5 gives C=0, Z=1.
  - 0x8000−1 gives C=0x7FFF, V=1, N=0.
  - AND 0xF0F0 with 0x0FF0 gives 0x00F0, V=0.
  - NOT of 0 gives 0xFFFF, N=1.
- Shifts and selects:
  - B=0x8001: `shift`=10 → 0x4000; `shift`=11 → 0xC000.
  - `bsel`=1 with `sximm5`=0xFFFF and `asel`=1 → C=0xFFFF.
  - `vsel`=01 with PC=0xAB writes 0x00AB; `vsel`=11 writes `mdata`.
- Reset: drop `rst_n` mid-operation between edges → C, Z, N, V and all registers read 0 immediately. `loads`=0 holds the flags while C updates.

Source files
------------

// File: rtl/srm_pkg.sv
// Shared definitions for the Simple RISC Machine datapath.
// Provides the data width and register count, and the encodings of the
// write-back select, B-operand shifter and ALU operation controls, plus the
// packed layout of the status register.
package srm_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned ADDR_W = 3;

    // Write-back source select (vsel)
    typedef enum logic [1:0] {
        VSEL_C     = 2'b00,
        VSEL_PC    = 2'b01,
        VSEL_IMM8  = 2'b10,
        VSEL_MDATA = 2'b11
    } vsel_e;

    // Shifter operation on the B operand (shift)
    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_e;

    // ALU operation (ALUop)
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_e;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
    } status_t;

endpackage

// File: rtl/srm_regfile.sv
// 8 x 16-bit register file for the SRM datapath.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low clear of all registers
//   write        - write enable; writenum selects the target register
//   data_in      - write data, captured on clk rise
//   readnum      - combinational read index
//   data_out     - R[readnum]; a write becomes visible after its edge
module srm_regfile
    import srm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] readnum,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write) begin
            regs[writenum] <= data_in;
        end
    end

    assign data_out = regs[readnum];

endmodule

// File: rtl/srm_datapath.sv
// Simple RISC Machine datapath.
// Register file -> A/B operand registers -> B shifter -> ALU -> C and
// status {Z,N,V}; C feeds back through the write-back mux.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset of all state
//   mdata, sximm8, PC   - write-back sources (PC zero-extended)
//   sximm5              - alternate ALU B input
//   write, vsel         - register-file write enable and write-back select
//   writenum, readnum   - register-file write / read indices
//   loada, loadb        - operand register load enables
//   asel, bsel          - ALU A forced to 0 / ALU B from sximm5
//   shift, ALUop        - shifter and ALU operation
//   loadc, loads        - result and status load enables
//   datapath_out        - C register
//   Z, N, V             - status register
module srm_datapath
    import srm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mdata,
    input  logic [DATA_W-1:0] sximm8,
    input  logic [DATA_W-1:0] sximm5,
    input  logic [7:0]        PC,
    input  logic              write,
    input  logic [1:0]        vsel,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [ADDR_W-1:0] readnum,
    input  logic              loada,
    input  logic              loadb,
    input  logic              asel,
    input  logic              bsel,
    input  logic [1:0]        shift,
    input  logic [1:0]        ALUop,
    input  logic              loadc,
    input  logic              loads,
    output logic [DATA_W-1:0] datapath_out,
    output logic              Z,
    output logic              N,
    output logic              V
);

    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] c_reg;
    logic [DATA_W-1:0] b_shifted;
    logic [DATA_W-1:0] ain;
    logic [DATA_W-1:0] bin;
    logic [DATA_W-1:0] alu_result;
    logic              alu_v;
    status_t           status_q;
    status_t           status_d;

    // Write-back mux; VSEL_C uses the registered C, so a same-edge loadc
    // writes the previous result.
    always_comb begin
        wb_data = c_reg;
        case (vsel_e'(vsel))
            VSEL_C:     wb_data = c_reg;
            VSEL_PC:    wb_data = {{(DATA_W-8){1'b0}}, PC};
            VSEL_IMM8:  wb_data = sximm8;
            VSEL_MDATA: wb_data = mdata;
            default:    wb_data = c_reg;
        endcase
    end

    srm_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .write    (write),
        .writenum (writenum),
        .data_in  (wb_data),
        .readnum  (readnum),
        .data_out (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (loada) a_reg <= rd_data;
            if (loadb) b_reg <= rd_data;
        end
    end

    always_comb begin
        b_shifted = b_reg;
        case (shift_e'(shift))
            SH_PASS: b_shifted = b_reg;
            SH_LSL:  b_shifted = {b_reg[DATA_W-2:0], 1'b0};
            SH_LSR:  b_shifted = {1'b0, b_reg[DATA_W-1:1]};
            SH_ASR:  b_shifted = {b_reg[DATA_W-1], b_reg[DATA_W-1:1]};
            default: b_shifted = b_reg;
        endcase
    end

    assign ain = asel ? '0 : a_reg;
    assign bin = bsel ? sximm5 : b_shifted;

    // Overflow: add overflows when both operands share a sign the result
    // lacks; subtract when operand signs differ and the result sign leaves Ain's.
    always_comb begin
        alu_result = '0;
        alu_v      = 1'b0;
        case (alu_e'(ALUop))
            ALU_ADD: begin
                alu_result = ain + bin;
                alu_v = (ain[DATA_W-1] == bin[DATA_W-1]) &&
                        (alu_result[DATA_W-1] != ain[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_result = ain - bin;
                alu_v = (ain[DATA_W-1] != bin[DATA_W-1]) &&
                        (alu_result[DATA_W-1] != ain[DATA_W-1]);
            end
            ALU_AND: alu_result = ain & bin;
            ALU_NOT: alu_result = ~bin;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        status_d.z = (alu_result == '0);
        status_d.n = alu_result[DATA_W-1];
        status_d.v = alu_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg    <= '0;
            status_q <= '0;
        end else begin
            if (loadc) c_reg    <= alu_result;
            if (loads) status_q <= status_d;
        end
    end

    assign datapath_out = c_reg;
    assign Z = status_q.z;
    assign N = status_q.n;
    assign V = status_q.v;

endmodule

// File: tb/tb_srm_datapath.sv
module tb_srm_datapath;
    import srm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] mdata, sximm8, sximm5;
    logic [7:0]  PC;
    logic        write;
    logic [1:0]  vsel;
    logic [2:0]  writenum, readnum;
    logic        loada, loadb, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic        loadc, loads;
    logic [15:0] datapath_out;
    logic        Z, N, V;

    int checks = 0;
    int failures = 0;

    srm_datapath dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mdata        (mdata),
        .sximm8       (sximm8),
        .sximm5       (sximm5),
        .PC           (PC),
        .write        (write),
        .vsel         (vsel),
        .writenum     (writenum),
        .readnum      (readnum),
        .loada        (loada),
        .loadb        (loadb),
        .asel         (asel),
        .bsel         (bsel),
        .shift        (shift),
        .ALUop        (ALUop),
        .loadc        (loadc),
        .loads        (loads),
        .datapath_out (datapath_out),
        .Z            (Z),
        .N            (N),
        .V            (V)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  sh;
        logic [1:0]  op;
        logic        as;
        logic        bs;
        logic [15:0] imm5;
        logic [15:0] c;
        logic        z;
        logic        n;
        logic        v;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        write = 0; vsel = 0; writenum = 0; readnum = 0;
        loada = 0; loadb = 0; asel = 0; bsel = 0;
        shift = 0; ALUop = 0; loadc = 0; loads = 0;
    endtask

    task automatic wr_imm(input logic [2:0] r, input logic [15:0] val);
        clear_ctl();
        vsel = 2'b10; sximm8 = val; writenum = r; write = 1;
        cycle();
        clear_ctl();
    endtask

    task automatic load_ab(input logic [2:0] ra, input logic [2:0] rb);
        clear_ctl();
        readnum = ra; loada = 1;
        cycle();
        clear_ctl();
        readnum = rb; loadb = 1;
        cycle();
        clear_ctl();
    endtask

    task automatic exec(input logic [1:0] sh, input logic [1:0] op, input logic as,
                        input logic bs, input logic [15:0] imm5, input logic ld_s);
        clear_ctl();
        shift = sh; ALUop = op; asel = as; bsel = bs; sximm5 = imm5;
        loadc = 1; loads = ld_s;
        cycle();
        clear_ctl();
    endtask

    // Route R[r] through B -> 0+B -> C without touching the flags.
    task automatic read_reg(input logic [2:0] r, output logic [15:0] val);
        clear_ctl();
        readnum = r; loadb = 1; asel = 1; ALUop = 2'b00; loadc = 1;
        cycle();
        cycle();
        clear_ctl();
        val = datapath_out;
    endtask

    logic [15:0] rv;

    initial begin
        //           a        b        sh     op     as bs imm5     c        z n v
        vecs[0]  = '{16'd2,   16'd7,   2'b01, 2'b00, 0, 0, 16'h0,   16'd16,  0,0,0};
        vecs[1]  = '{16'd13,  16'd42,  2'b00, 2'b00, 0, 0, 16'h0,   16'd55,  0,0,0};
        vecs[2]  = '{16'd13,  16'd42,  2'b00, 2'b00, 1, 0, 16'h0,   16'd42,  0,0,0};
        vecs[3]  = '{16'd20000,16'd20000,2'b00,2'b00,0, 0, 16'h0,   16'h9C40,0,1,1};
        vecs[4]  = '{16'd5,   16'd5,   2'b00, 2'b01, 0, 0, 16'h0,   16'h0000,1,0,0};
        vecs[5]  = '{16'h8000,16'h0001,2'b00, 2'b01, 0, 0, 16'h0,   16'h7FFF,0,0,1};
        vecs[6]  = '{16'hF0F0,16'h0FF0,2'b00, 2'b10, 0, 0, 16'h0,   16'h00F0,0,0,0};
        vecs[7]  = '{16'h1234,16'h0000,2'b00, 2'b11, 0, 0, 16'h0,   16'hFFFF,0,1,0};
        vecs[8]  = '{16'h0000,16'h8001,2'b10, 2'b00, 1, 0, 16'h0,   16'h4000,0,0,0};
        vecs[9]  = '{16'h0000,16'h8001,2'b11, 2'b00, 1, 0, 16'h0,   16'hC000,0,1,0};
        vecs[10] = '{16'h5555,16'h1234,2'b00, 2'b00, 1, 1, 16'hFFFF,16'hFFFF,0,1,0};
        vecs[11] = '{16'd3,   16'd5,   2'b00, 2'b01, 0, 0, 16'h0,   16'hFFFE,0,1,0};
        vecs[12] = '{16'h7FFF,16'hFFFF,2'b00, 2'b01, 0, 0, 16'h0,   16'h8000,0,1,1};
        vecs[13] = '{16'h8000,16'h8000,2'b00, 2'b00, 0, 0, 16'h0,   16'h0000,1,0,1};
        vecs[14] = '{16'hFFFF,16'h8001,2'b01, 2'b10, 0, 0, 16'h0,   16'h0002,0,0,0};

        mdata = 0; sximm8 = 0; sximm5 = 0; PC = 0;
        clear_ctl();
        rst_n = 0;
        #3;
        chk("rst_c", datapath_out, 16'h0);
        chk("rst_flags", {13'b0, Z, N, V}, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 15; i++) begin
            wr_imm(3'd1, vecs[i].a);
            wr_imm(3'd2, vecs[i].b);
            load_ab(3'd1, 3'd2);
            exec(vecs[i].sh, vecs[i].op, vecs[i].as, vecs[i].bs, vecs[i].imm5, 1'b1);
            chk($sformatf("v%0d_c", i), datapath_out, vecs[i].c);
            chk($sformatf("v%0d_z", i), {15'b0, Z}, {15'b0, vecs[i].z});
            chk($sformatf("v%0d_n", i), {15'b0, N}, {15'b0, vecs[i].n});
            chk($sformatf("v%0d_v", i), {15'b0, V}, {15'b0, vecs[i].v});
        end

        // MOV / shift / add, then write C back to R2
        wr_imm(3'd0, 16'd7);
        wr_imm(3'd1, 16'd2);
        load_ab(3'd1, 3'd0);
        exec(2'b01, 2'b00, 0, 0, 16'h0, 1'b1);
        chk("mov_c", datapath_out, 16'd16);
        clear_ctl(); vsel = 2'b00; writenum = 3'd2; write = 1;
        cycle();
        clear_ctl();
        read_reg(3'd2, rv);
        chk("wb_r2", rv, 16'd16);

        // Same-edge loadc + write-back writes the old C
        load_ab(3'd0, 3'd1);
        clear_ctl();
        ALUop = 2'b00; loadc = 1; vsel = 2'b00; writenum = 3'd3; write = 1;
        cycle();
        clear_ctl();
        chk("same_edge_c", datapath_out, 16'd9);
        read_reg(3'd3, rv);
        chk("same_edge_r3", rv, 16'd16);

        // Same-edge loada + write to same register captures the old value
        wr_imm(3'd4, 16'h1111);
        clear_ctl();
        readnum = 3'd4; loada = 1; vsel = 2'b10; sximm8 = 16'h2222; writenum = 3'd4; write = 1;
        cycle();
        clear_ctl();
        exec(2'b00, 2'b10, 0, 1, 16'hFFFF, 1'b0);
        chk("loada_old", datapath_out, 16'h1111);
        read_reg(3'd4, rv);
        chk("loada_new_r4", rv, 16'h2222);

        // PC and mdata write-back sources
        clear_ctl(); PC = 8'hAB; vsel = 2'b01; writenum = 3'd5; write = 1;
        cycle();
        clear_ctl(); mdata = 16'hBEEF; vsel = 2'b11; writenum = 3'd6; write = 1;
        cycle();
        clear_ctl();
        read_reg(3'd5, rv);
        chk("wb_pc", rv, 16'h00AB);
        read_reg(3'd6, rv);
        chk("wb_mdata", rv, 16'hBEEF);

        // loads=0 holds the flags while C updates
        exec(2'b00, 2'b00, 1, 1, 16'h0000, 1'b1);
        chk("hold_pre_z", {15'b0, Z}, 16'h1);
        exec(2'b00, 2'b11, 1, 1, 16'h0000, 1'b0);
        chk("hold_c", datapath_out, 16'hFFFF);
        chk("hold_z", {15'b0, Z}, 16'h1);
        chk("hold_n", {15'b0, N}, 16'h0);

        // Asynchronous reset between edges
        #2;
        rst_n = 0;
        #1;
        chk("arst_c", datapath_out, 16'h0);
        chk("arst_flags", {13'b0, Z, N, V}, 16'h0);
        @(negedge clk);
        rst_n = 1;
        for (int r = 0; r < 8; r++) begin
            read_reg(r[2:0], rv);
            chk($sformatf("arst_r%0d", r), rv, 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
